// File: rtl/obi_rready_buffer_if.sv
// Handshake and payload bundle around obi_rready_buffer.
// The slave modport is the buffer's view; the master modport is the surrounding system's view.
interface obi_rready_buffer_if #(
    parameter type a_t = logic,
    parameter type r_t = logic
);
    a_t   sbr_a_chan_i;
    logic req_i;
    logic gnt_o;
    r_t   sbr_r_chan_o;
    logic rvalid_o;
    logic rready_i;
    a_t   mgr_a_chan_o;
    logic req_o;
    logic gnt_i;
    r_t   mgr_r_chan_i;
    logic rvalid_i;

    modport slave (
        input  sbr_a_chan_i, req_i, rready_i, gnt_i, mgr_r_chan_i, rvalid_i,
        output gnt_o, sbr_r_chan_o, rvalid_o, mgr_a_chan_o, req_o
    );

    modport master (
        output sbr_a_chan_i, req_i, rready_i, gnt_i, mgr_r_chan_i, rvalid_i,
        input  gnt_o, sbr_r_chan_o, rvalid_o, mgr_a_chan_o, req_o
    );
endinterface

// File: rtl/obi_rready_buffer.sv
// OBI rready converter: reserves a response slot before admitting a request, buffers R, drains on quiesce.
// Optional macro OBI_RREADY_BUFFER_STATS_EN adds the stall_cnt_o request-stall counter.
module obi_rready_buffer #(
    parameter type          obi_a_chan_t = logic,
    parameter type          obi_r_chan_t = logic,
    parameter int unsigned  Depth        = 2,
    parameter bit           FallThrough  = 1'b1,
    localparam int unsigned CntW         = $clog2(Depth + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               test_mode_i,
    obi_rready_buffer_if.slave bus,
    input  logic               quiesce_i,
    output logic               idle_o,
    output logic [CntW-1:0]    credits_o
`ifdef OBI_RREADY_BUFFER_STATS_EN
    ,
    output logic [31:0]        stall_cnt_o
`endif
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    if (Depth < 1) begin : g_depth_check
        $fatal(1, "obi_rready_buffer: Depth must be >= 1");
    end

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_IDLE} state_e;

    state_e          state_q;
    logic            idle_q;
    logic [CntW-1:0] out_q, out_d;
    logic [CntW-1:0] fill_q, fill_d;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    obi_r_chan_t     mem_q [Depth];
    obi_a_chan_t     a_pass_c;

    logic run_c, empty_c, full_c, bypass_c, rvalid_c;
    logic pop_c, mem_pop_c, push_c, allow_c, grant_c;
    logic unused_c;

    assign unused_c = test_mode_i;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Slot accounting: a pop in the same cycle frees a slot for a new grant.
    assign run_c     = (state_q == ST_RUN);
    assign empty_c   = (fill_q == '0);
    assign full_c    = (fill_q == CntW'(Depth));
    assign bypass_c  = FallThrough && empty_c;
    assign rvalid_c  = bypass_c ? bus.rvalid_i : !empty_c;
    assign pop_c     = rvalid_c && bus.rready_i;
    assign mem_pop_c = pop_c && !empty_c;
    assign push_c    = bus.rvalid_i && !(bypass_c && pop_c) && (!full_c || mem_pop_c);
    assign allow_c   = (out_q < CntW'(Depth)) || pop_c;
    assign grant_c   = bus.req_o && bus.gnt_i;

    assign a_pass_c         = bus.sbr_a_chan_i;
    assign bus.mgr_a_chan_o = a_pass_c;
    assign bus.req_o        = bus.req_i && allow_c && run_c;
    assign bus.gnt_o        = bus.gnt_i && allow_c && run_c;
    assign bus.rvalid_o     = rvalid_c;
    assign bus.sbr_r_chan_o = bypass_c ? bus.mgr_r_chan_i : mem_q[rd_ptr_q];

    assign credits_o = CntW'(Depth) - out_q;
    assign idle_o    = idle_q;

    always_comb begin
        out_d  = out_q;
        fill_d = fill_q;
        if (grant_c && !pop_c) begin
            out_d = out_q + CntW'(1);
        end else if (!grant_c && pop_c) begin
            out_d = out_q - CntW'(1);
        end
        if (push_c && !mem_pop_c) begin
            fill_d = fill_q + CntW'(1);
        end else if (!push_c && mem_pop_c) begin
            fill_d = fill_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q    <= '0;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            out_q  <= out_d;
            fill_q <= fill_d;
            if (push_c) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (mem_pop_c) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by fill_q.
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= bus.mgr_r_chan_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            idle_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (quiesce_i) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!quiesce_i) begin
                        state_q <= ST_RUN;
                    end else if (out_q == '0) begin
                        state_q <= ST_IDLE;
                        idle_q  <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (!quiesce_i) begin
                        state_q <= ST_RUN;
                        idle_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    idle_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef OBI_RREADY_BUFFER_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (bus.req_i && !bus.gnt_o && run_c && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

    // The credit scheme guarantees a free slot for every response.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(bus.rvalid_i && full_c && !mem_pop_c))
        else $error("obi_rready_buffer: response arrived with buffer full, entry dropped");

endmodule

// File: tb/tb_obi_rready_buffer.sv
// Randomized scoreboard bench for obi_rready_buffer across three Depth/FallThrough configurations.
`timescale 1ns/1ps
module tb_obi_rready_buffer;
    localparam int unsigned NCFG = 3;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic quiesce   = 1'b0;
    logic test_mode = 1'b0;
    int   rr_mode   = 0;      // 0: random rready, 1: always ready, 2: never ready
    int   n_chk     = 0;
    int   n_pass    = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int cfg, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cfg%0d t=%0t: got %0d expected %0d", nm, cfg, $time, act, exp);
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int unsigned D  = (g == 0) ? 2 : (g == 1) ? 3 : 1;
        localparam bit          FT = (g == 0);
        localparam int unsigned CW = $clog2(D + 1);

        obi_rready_buffer_if #(.a_t(logic [7:0]), .r_t(logic [7:0])) bus ();
        logic          idle;
        logic [CW-1:0] credits;
        logic [7:0]    exp_q [$];
`ifdef OBI_RREADY_BUFFER_STATS_EN
        logic [31:0]   stall_cnt;
`endif

        obi_rready_buffer #(
            .obi_a_chan_t (logic [7:0]),
            .obi_r_chan_t (logic [7:0]),
            .Depth        (D),
            .FallThrough  (FT)
        ) dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .test_mode_i (test_mode),
            .bus         (bus),
            .quiesce_i   (quiesce),
            .idle_o      (idle),
`ifdef OBI_RREADY_BUFFER_STATS_EN
            .stall_cnt_o (stall_cnt),
`endif
            .credits_o   (credits)
        );

        // Manager and subordinate stimulus; subordinate answers one cycle after a grant.
        initial begin : drive
            logic       hs, gr;
            logic [7:0] addr;
            bus.req_i        = 1'b0;
            bus.sbr_a_chan_i = '0;
            bus.rready_i     = 1'b0;
            bus.gnt_i        = 1'b0;
            bus.mgr_r_chan_i = '0;
            bus.rvalid_i     = 1'b0;
            forever begin
                @(negedge clk);
                hs   = bus.req_i && bus.gnt_o;
                gr   = bus.req_o && bus.gnt_i;
                addr = bus.sbr_a_chan_i;
                @(posedge clk);
                #1;
                if (rst) begin
                    exp_q.delete();
                    bus.req_i    = 1'b0;
                    bus.rvalid_i = 1'b0;
                    bus.gnt_i    = 1'b0;
                    bus.rready_i = 1'b0;
                end else begin
                    if (gr) exp_q.push_back(addr ^ 8'h5A);
                    bus.rvalid_i     = gr;
                    bus.mgr_r_chan_i = gr ? (addr ^ 8'h5A) : 8'($urandom);
                    if (!bus.req_i || hs) begin
                        bus.req_i        = ($urandom_range(0, 9) < 7);
                        bus.sbr_a_chan_i = 8'($urandom);
                    end
                    bus.gnt_i    = ($urandom_range(0, 9) < 8);
                    bus.rready_i = (rr_mode == 1) ? 1'b1 :
                                   (rr_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
                end
            end
        end

        // Reference model: outstanding count, buffered count and quiesce mode; data via exp_q.
        initial begin : monitor
            int   outst, nb, mode;
            logic e_rv, e_pop, e_allow, e_run, e_req, e_gnt;
`ifdef OBI_RREADY_BUFFER_STATS_EN
            longint stall;
            stall = 0;
`endif
            outst = 0; nb = 0; mode = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    outst = 0; nb = 0; mode = 0;
                    chk("rst_credits", g, credits, D);
                    chk("rst_idle", g, idle, 0);
                    chk("rst_rvalid", g, bus.rvalid_o, 0);
`ifdef OBI_RREADY_BUFFER_STATS_EN
                    stall = 0;
                    chk("rst_stall", g, stall_cnt, 0);
`endif
                end else begin
                    e_run   = (mode == 0);
                    e_rv    = (nb > 0) || (FT && bus.rvalid_i);
                    e_pop   = e_rv && bus.rready_i;
                    e_allow = (outst < int'(D)) || e_pop;
                    e_req   = bus.req_i && e_allow && e_run;
                    e_gnt   = bus.gnt_i && e_allow && e_run;
                    chk("rvalid_o", g, bus.rvalid_o, e_rv);
                    chk("req_o", g, bus.req_o, e_req);
                    chk("gnt_o", g, bus.gnt_o, e_gnt);
                    chk("credits_o", g, credits, int'(D) - outst);
                    chk("idle_o", g, idle, mode == 2);
                    chk("a_chan", g, bus.mgr_a_chan_o, bus.sbr_a_chan_i);
`ifdef OBI_RREADY_BUFFER_STATS_EN
                    chk("stall_cnt", g, stall_cnt, stall);
                    if (bus.req_i && !e_gnt && e_run && stall < 64'hFFFF_FFFF) stall++;
`endif
                    if (e_pop) begin
                        chk("sb_nonempty", g, exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) chk("r_data", g, bus.sbr_r_chan_o, exp_q.pop_front());
                    end
                    case (mode)
                        0:       if (quiesce) mode = 1;
                        1:       if (!quiesce) mode = 0; else if (outst == 0) mode = 2;
                        default: if (!quiesce) mode = 0;
                    endcase
                    outst += int'(e_req && bus.gnt_i) - int'(e_pop);
                    if (!(FT && nb == 0 && bus.rvalid_i && e_pop))
                        nb += int'(bus.rvalid_i) - int'(e_pop);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        cycles(400);
        rr_mode = 2;            // manager stalls R: buffers fill, credits reach 0
        cycles(20);
        rr_mode = 1;            // release: pending request granted alongside the pop
        cycles(60);
        rr_mode = 0;
        quiesce = 1'b1;         // drain to idle
        cycles(30);
        quiesce = 1'b0;
        cycles(50);
        quiesce = 1'b1;         // short blip back out of DRAIN
        cycles(1);
        quiesce = 1'b0;
        cycles(300);
        @(posedge clk);
        rst = 1'b1;             // reset in mid traffic
        cycles(2);
        #1 rst = 1'b0;
        cycles(300);
        rr_mode = 1;
        quiesce = 1'b1;
        cycles(25);
        @(negedge clk);
        chk("final_idle", 0, g_cfg[0].idle, 1);
        chk("final_idle", 1, g_cfg[1].idle, 1);
        chk("final_idle", 2, g_cfg[2].idle, 1);
        chk("final_drained", 0, g_cfg[0].exp_q.size(), 0);
        chk("final_drained", 1, g_cfg[1].exp_q.size(), 0);
        chk("final_drained", 2, g_cfg[2].exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
